// File: rtl/ila_readout_pkg.sv
// Shared ILA definitions: readout FSM encodings and slice-select geometry.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package ila_readout_pkg;

    // Readout FSM state encodings
    typedef enum logic [1:0] {
        ILA_RO_IDLE = 2'd0,
        ILA_RO_WAIT = 2'd1,
        ILA_RO_SEND = 2'd2,
        ILA_RO_DONE = 2'd3
    } ila_ro_state_e;

    // Number of DATA_W slices per captured sample; the capture core uses the
    // same function so both sides agree on slice count and ordering.
    function automatic int ila_parts(input int data_w, input int signal_w);
        return (data_w >= signal_w) ? 1 : signal_w / data_w;
    endfunction

    // Width of the slice select; kept at least one bit so the port always exists.
    function automatic int ila_sel_w(input int data_w, input int signal_w);
        return (data_w >= signal_w) ? 1 : $clog2(signal_w / data_w);
    endfunction

endpackage

// File: rtl/ila_readout.sv
// ILA readout: walks every sample index and slice of the capture buffer, emitting one stream word per slice.
// Latency: first word valid READ_LAT+2 cycles after start; one word per READ_LAT+2 cycles with m_ready held high.
// Backpressure: m_data/m_last/m_valid hold while m_ready=0; the walk pauses until the word is accepted.
module ila_readout
    import ila_readout_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int SIGNAL_W = 32,
    parameter int BUFFER_W = 10,
    parameter int READ_LAT = 1,
    localparam int PARTS   = ila_parts(DATA_W, SIGNAL_W),
    localparam int SEL_W   = ila_sel_w(DATA_W, SIGNAL_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [BUFFER_W-1:0] samples,
    output logic [BUFFER_W-1:0] index,
    output logic [SEL_W-1:0]    value_select,
    input  logic [DATA_W-1:0]   value,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_last,
    output logic                busy,
    output logic                done
);

    // Latency counter must reach READ_LAT; sized for READ_LAT+1 to leave headroom.
    localparam int LAT_W = $clog2(READ_LAT + 2);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(PARTS - 1);
    localparam logic [LAT_W-1:0] LAT_FIRE = LAT_W'(READ_LAT);

    ila_ro_state_e         state_q;
    logic [BUFFER_W-1:0]   cnt_q;
    logic [BUFFER_W-1:0]   index_q;
    logic [SEL_W-1:0]      sel_q;
    logic [LAT_W-1:0]      lat_q;
    logic [DATA_W-1:0]     data_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  busy_q;
    logic                  done_q;

    logic [BUFFER_W-1:0]   last_index;
    logic                  is_last_word;

    // cnt_q is never zero outside IDLE/DONE, so the decrement cannot underflow where it matters.
    assign last_index   = cnt_q - BUFFER_W'(1);
    assign is_last_word = (cnt_q != '0) && (index_q == last_index) && (sel_q == SEL_LAST);

    assign index        = index_q;
    assign value_select = sel_q;
    assign m_valid      = valid_q;
    assign m_data       = data_q;
    assign m_last       = last_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // Readout FSM with registered outputs: snapshot count, wait out read latency, hand off each slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ILA_RO_IDLE;
            cnt_q   <= '0;
            index_q <= '0;
            sel_q   <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ILA_RO_IDLE: begin
                    if (start) begin
                        cnt_q   <= samples;
                        index_q <= '0;
                        sel_q   <= '0;
                        lat_q   <= '0;
                        busy_q  <= 1'b1;
                        if (samples == '0) begin
                            state_q <= ILA_RO_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ILA_RO_WAIT;
                        end
                    end
                end
                ILA_RO_WAIT: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= ILA_RO_DONE;
                        done_q  <= 1'b1;
                    end else if (lat_q == LAT_FIRE) begin
                        // Address has been stable for READ_LAT+1 cycles: read data is valid now.
                        data_q  <= value;
                        valid_q <= 1'b1;
                        last_q  <= is_last_word;
                        state_q <= ILA_RO_SEND;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                ILA_RO_SEND: begin
                    if (abort) begin
                        // Abort wins over a same-cycle handshake; the pending word is dropped.
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= ILA_RO_DONE;
                        done_q  <= 1'b1;
                    end else if (m_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (last_q) begin
                            state_q <= ILA_RO_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            if (sel_q == SEL_LAST) begin
                                sel_q   <= '0;
                                index_q <= index_q + BUFFER_W'(1);
                            end else begin
                                sel_q <= sel_q + SEL_W'(1);
                            end
                            lat_q   <= '0;
                            state_q <= ILA_RO_WAIT;
                        end
                    end
                end
                ILA_RO_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ILA_RO_IDLE;
                end
                default: begin
                    state_q <= ILA_RO_IDLE;
                end
            endcase
        end
    end

endmodule
